// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds default widths, the sequencer state encoding and requester indices.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester channels plus the single-port memory bus.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);

    logic                         fixed_prio;
    logic [1:0]                   req;
    logic [1:0]                   we;
    logic [1:0][ADDR_W-1:0]       addr;
    logic [1:0][DATA_W-1:0]       wdata;
    logic [1:0]                   gnt;
    logic [1:0]                   rvalid;
    logic [1:0][DATA_W-1:0]       rdata;

    logic [ADDR_W-1:0]            mem_raddr;
    logic [ADDR_W-1:0]            mem_waddr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         mem_re;
    logic                         mem_we;
    logic [DATA_W-1:0]            mem_rdata;

    modport slave (
        input  fixed_prio, req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_raddr, mem_waddr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output fixed_prio, req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_raddr, mem_waddr, mem_wdata, mem_re, mem_we
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way winner select: fixed priority to requester 0, or
// round-robin where a contended slot goes to whoever was not granted last.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    input  logic fixed_prio_i,
    output logic win_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        win_o   = 1'b0;
        if (req0_i && req1_i) begin
            win_o = fixed_prio_i ? 1'b0 : ~last_gnt_i;
        end else if (req1_i) begin
            win_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and debug accesses onto the single-port data memory.
// Each access takes an ACCESS cycle (grant + memory strobe) then a RESP cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    state_e                 state_q, state_d;
    logic                   winner_q, winner_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   last_gnt_q, last_gnt_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic                   pick_win;
    logic                   pick_valid;

    logic [1:0]             gnt;
    logic [1:0]             rvalid;
    logic [ADDR_W-1:0]      mem_raddr;
    logic [ADDR_W-1:0]      mem_waddr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_re;
    logic                   mem_we;

    rr_pick2 u_pick (
        .req0_i       (bus.req[REQ_CORE]),
        .req1_i       (bus.req[REQ_DBG]),
        .last_gnt_i   (last_gnt_q),
        .fixed_prio_i (bus.fixed_prio),
        .win_o        (pick_win),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        gnt        = '0;
        rvalid     = '0;
        mem_raddr  = '0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            StIdle, StResp: begin
                if (state_q == StResp) begin
                    rvalid[winner_q] = ~we_q;
                end
                // RESP doubles as the next arbitration point to sustain one access per 2 cycles.
                if (pick_valid) begin
                    winner_d = pick_win;
                    we_d     = bus.we[pick_win];
                    addr_d   = bus.addr[pick_win];
                    wdata_d  = bus.wdata[pick_win];
                    state_d  = StAccess;
                end else begin
                    state_d  = StIdle;
                end
            end
            StAccess: begin
                gnt[winner_q] = 1'b1;
                mem_raddr     = addr_q;
                mem_waddr     = addr_q;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_re            = 1'b1;
                    rdata_d[winner_q] = bus.mem_rdata;
                end
                last_gnt_d = winner_q;
                state_d    = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            winner_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_gnt_q <= 1'b1;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rvalid;
    assign bus.rdata     = rdata_q;
    assign bus.mem_raddr = mem_raddr;
    assign bus.mem_waddr = mem_waddr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected grant order
// and read data; a negedge monitor pops and compares, and checks bus invariants.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        fixed_prio = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;

    assign bus.fixed_prio = fixed_prio;
    assign bus.req        = {req1, req0};
    assign bus.we         = {we1, we0};
    assign bus.addr       = {addr1, addr0};
    assign bus.wdata      = {wdata1, wdata0};

    logic [31:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_raddr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          gnt_q[$];
    int          gnt_cyc_q[$];
    logic [31:0] rd_q0[$];
    logic [31:0] rd_q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic [7:0] a,
                           input logic [31:0] d);
        if (i == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Holds the request for n grants, dropping it on the negedge of the last grant.
    task automatic hold_req(input int i, input logic w, input logic [7:0] a,
                            input logic [31:0] d, input int n);
        int got = 0;
        set_req(i, 1'b1, w, a, d);
        for (int k = 0; k < 100 && got < n; k++) begin
            @(negedge clk);
            if (bus.gnt[i]) got++;
        end
        set_req(i, 1'b0, 1'b0, 8'h00, 32'h0);
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d got %0d grants expected %0d", i, got, n);
        end
    endtask

    logic [1:0] prev_rd = '0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            prev_rd = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.gnt[i]) begin
                    gnt_cyc_q.push_back(cyc);
                    if (gnt_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_gnt: got gnt%0d expected none", i);
                    end else begin
                        chk("gnt_order", 32'(i), 32'(gnt_q.pop_front()));
                    end
                end
                if (bus.rvalid[i]) begin
                    if ((i == 0 && rd_q0.size() == 0) || (i == 1 && rd_q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rvalid: got rvalid%0d expected none", i);
                    end else begin
                        e = (i == 0) ? rd_q0.pop_front() : rd_q1.pop_front();
                        chk("rdata", bus.rdata[i], e);
                    end
                end
            end
            chk("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 32'h0);
            chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
            chk("rvalid_after_read_gnt", 32'(bus.rvalid), 32'(prev_rd));
            if (bus.gnt == 2'b00) begin
                chk("idle_bus_zero", {bus.mem_raddr, bus.mem_waddr, 14'h0, bus.mem_we,
                                      bus.mem_re}, 32'h0);
                chk("idle_wdata_zero", bus.mem_wdata, 32'h0);
            end
            prev_rd = bus.gnt & {2{bus.mem_re}};
        end
    end

    // Requests may only be withdrawn on or after their grant.
    logic [1:0] pend = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                assert (!(pend[i] && !bus.req[i] && !bus.gnt[i])) else begin
                    bad++;
                    $display("FAIL protocol: req%0d dropped before gnt", i);
                end
            end
            pend <= bus.req & ~bus.gnt;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt_rvalid"}, {28'h0, bus.gnt, bus.rvalid}, 32'h0);
        chk({tag, "_mem_strobes"}, {30'h0, bus.mem_we, bus.mem_re}, 32'h0);
        chk({tag, "_mem_addr"}, {16'h0, bus.mem_raddr, bus.mem_waddr}, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_rdata0"}, bus.rdata[0], 32'h0);
        chk({tag, "_rdata1"}, bus.rdata[1], 32'h0);
    endtask

    initial begin
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h20] = 32'hA5A5_0001;
        mem[8'h30] = 32'h0BAD_CAFE;
        mem[8'hFF] = 32'h0000_0000;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read with latency checks.
        gnt_q.push_back(0);
        rd_q0.push_back(32'hDEAD_BEEF);
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        chk("read_gnt_cycle", 32'(bus.gnt), 32'h1);
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("read_rvalid_cycle", 32'(bus.rvalid), 32'h1);
        chk("read_rdata0", bus.rdata[0], 32'hDEAD_BEEF);

        // Debug write, then core read-back.
        gnt_q.push_back(1);
        set_req(1, 1'b1, 1'b1, 8'hFF, 32'h1234_5678);
        @(negedge clk);
        chk("write_gnt", 32'(bus.gnt), 32'h2);
        chk("write_we", {bus.mem_we, bus.mem_re}, 32'h2);
        chk("write_waddr", 32'(bus.mem_waddr), 32'hFF);
        chk("write_wdata", bus.mem_wdata, 32'h1234_5678);
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("write_we_one_cycle", 32'(bus.mem_we), 32'h0);
        chk("write_no_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rdata0_held", bus.rdata[0], 32'hDEAD_BEEF);
        gnt_q.push_back(0);
        rd_q0.push_back(32'h1234_5678);
        hold_req(0, 1'b0, 8'hFF, 32'h0, 1);

        // Debug read so that last_gnt = 1 before the contended run.
        gnt_q.push_back(1);
        rd_q1.push_back(32'hDEAD_BEEF);
        hold_req(1, 1'b0, 8'h10, 32'h0, 1);

        // Round-robin contention: 8 grants alternating 0,1,...
        fixed_prio = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(0);
            gnt_q.push_back(1);
            rd_q0.push_back(32'hDEAD_BEEF);
            rd_q1.push_back(32'h1234_5678);
        end
        gnt_cyc_q.delete();
        fork
            hold_req(0, 1'b0, 8'h10, 32'h0, 4);
            hold_req(1, 1'b0, 8'hFF, 32'h0, 4);
        join
        chk("rr_grant_count", 32'(gnt_cyc_q.size()), 32'd8);
        for (int k = 1; k < gnt_cyc_q.size(); k++) begin
            chk("rr_grant_spacing", 32'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 32'd2);
        end

        // Fixed priority: core takes three grants, then debug.
        fixed_prio = 1'b1;
        repeat (3) begin
            gnt_q.push_back(0);
            rd_q0.push_back(32'hA5A5_0001);
        end
        gnt_q.push_back(1);
        rd_q1.push_back(32'h0BAD_CAFE);
        fork
            hold_req(0, 1'b0, 8'h20, 32'h0, 3);
            hold_req(1, 1'b0, 8'h30, 32'h0, 1);
        join
        fixed_prio = 1'b0;
        @(negedge clk);

        // Reset in the ACCESS cycle of a write.
        gnt_q.push_back(1);
        set_req(1, 1'b1, 1'b1, 8'h40, 32'h5555_AAAA);
        @(negedge clk);
        chk("rst_write_in_access", {bus.gnt, bus.mem_we}, 32'h5);
        #1;
        rst_n = 1'b0;
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First contended round-robin slot after reset goes to the core.
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        rd_q0.push_back(32'hDEAD_BEEF);
        rd_q1.push_back(32'hA5A5_0001);
        fork
            hold_req(0, 1'b0, 8'h10, 32'h0, 1);
            hold_req(1, 1'b0, 8'h20, 32'h0, 1);
        join

        repeat (4) @(negedge clk);
        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'h0);
        chk("rd_queues_drained", 32'(rd_q0.size() + rd_q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the 256×32 single-port data memory. Serialises accesses from the core load/store unit (requester 0) and the debug/loader port (requester 1) onto one memory interface, with round-robin or fixed-priority selection, a req/gnt handshake and a registered read-data return. Sits between the pipeline MEM stage, the debug port and the data memory, and is the only driver of the memory's control and address inputs.

## Interface
Parameters:
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W.
- DATA_W, 32, data word width.

Ports (`i` ∈ {0, 1}; 0 = core, 1 = debug):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- fixed_prio  in  1  1 = requester 0 always wins; 0 = round-robin.
- req_i  in  1  access request, level; held until gnt_i.
- we_i  in  1  1 = write, 0 = read; valid while req_i.
- addr_i  in  ADDR_W  word address; valid while req_i.
- wdata_i  in  DATA_W  write data; valid while req_i and we_i.
- gnt_i  out  1  one-cycle pulse; the access is performed this cycle.
- rvalid_i  out  1  one-cycle pulse; rdata_i is valid (reads only).
- rdata_i  out  DATA_W  registered read data; holds its value until the next read for that requester.
- mem_raddr  out  ADDR_W  memory read address.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data; combinational from mem_raddr.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_i is high, latch the winner index, we, addr and wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - Assert gnt_winner.
  - Drive mem_raddr and mem_waddr from the latched addr.
  - If the latched we is 1, assert mem_we with mem_wdata; else assert mem_re and capture mem_rdata into rdata_winner at the clock edge.
  - Update last_gnt to the winner. Go to RESP.
- RESP (one cycle):
  - For a read, assert rvalid_winner.
  - Re-arbitrate exactly as in IDLE: with a request pending, latch it and go to ACCESS; otherwise go to IDLE.
- Arbitration:
  - fixed_prio = 1: requester 0 wins whenever req_0 is high.
  - fixed_prio = 0: if both requests are high, the requester that is not last_gnt wins. A single requester always wins.
- Handshake:
  - The requester holds req, we, addr and wdata stable until it sees gnt.
  - If req is still high in the cycle after gnt, it is a new transaction.
  - A req dropped before gnt is a protocol violation. The arbiter performs the latched access anyway; the bench flags it by assertion.
- mem_we and mem_re are never both high. Neither is high outside ACCESS.
- When not in ACCESS, memory address and data outputs are driven to 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE, last_gnt = 1 (requester 0 wins the first contended round-robin slot).
  - All gnt, rvalid, mem_we and mem_re = 0; all rdata, address and data outputs = 0.
- Latency: req seen high at edge N (state IDLE) → gnt in cycle N+1 → rvalid and rdata in cycle N+2.
- Throughput: with requests continuously pending, one access every 2 cycles (ACCESS and RESP alternate).
  - Under round-robin with both requests held, grants alternate 0, 1, 0, 1.
- Write then read of the same address, from either requester: the read (a later ACCESS) returns the newly written data.
- Simultaneous read from one requester and write from the other: serialised in arbitration order, never merged.
- Reset asserted during ACCESS: mem_we drops immediately and asynchronously. Whether that write lands in memory is undefined, and the bench does not check it.
- fixed_prio changes take effect at the next arbitration point (IDLE or RESP). A latched access is never affected.
- Address width: ADDR_W bits; no wrap or overflow handling is required.

## Structure
- Shared package `dmem_pkg`: ADDR_W and DATA_W defaults, the state enum (IDLE, ACCESS, RESP), and requester index constants REQ_CORE = 0 and REQ_DBG = 1.
- One sub-module, `rr_pick2`: combinational 2-way winner select from req_0, req_1, last_gnt and fixed_prio.
- Everything else (FSM, latch registers, rdata registers) stays in the top module.

## Test plan
- Reset then single read: memory preloaded with word 0x10 = 0xDEADBEEF; req_0 read addr 0x10 → gnt_0 in the 1st cycle after the req edge, rvalid_0 in the 2nd with rdata_0 = 0xDEADBEEF; gnt_1 and rvalid_1 stay 0.
- Write then read-back: req_1 writes 0x12345678 to 0xFF → mem_we high for exactly one cycle with mem_waddr = 0xFF; then req_0 reads 0xFF → rdata_0 = 0x12345678, no rvalid for the write.
- Round-robin contention: fixed_prio = 0, both reqs held for 8 grants → grant order 0, 1, 0, 1, 0, 1, 0, 1; one gnt every 2 cycles.
- Fixed priority: fixed_prio = 1, both reqs held for 3 grants → all three go to requester 0; drop req_0 → next gnt goes to requester 1.
- Reset mid-operation: assert rst_n = 0 during ACCESS of a write → mem_we = 0 in the same cycle, all outputs at reset values; after release, the first contended grant goes to requester 0.
- Invariants, checked every cycle: never mem_we and mem_re both high; at most one gnt high; rvalid only in the cycle after a read gnt.
